// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the burst-length lookup used by the bus arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HALF  = 3'b001,
    HSIZE_WORD  = 3'b010,
    HSIZE_DWORD = 3'b011,
    HSIZE_128   = 3'b100,
    HSIZE_256   = 3'b101,
    HSIZE_512   = 3'b110,
    HSIZE_1024  = 3'b111
  } hsize_e;

  localparam int BEAT_CNT_W = 4;

  // Beats remaining after the NONSEQ beat; undefined-length bursts count as 0.
  function automatic logic [BEAT_CNT_W-1:0] burst_beats_left(input hburst_e burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  return 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  return 4'd7;
      HBURST_WRAP16, HBURST_INCR16: return 4'd15;
      default:                      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational winner selection: round-robin starting after ptr_i, or
// lowest-index-first when ARB_FIXED_PRIO_EN is defined.
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_WIDTH   = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [MID_WIDTH-1:0]   ptr_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [MID_WIDTH-1:0]   idx_o,
  output logic                   any_o
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Descending scan so the lowest requesting index is the last write.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = MID_WIDTH'(i);
        any_o      = 1'b1;
      end
    end
  end
`else
  int                   cand;
  logic [MID_WIDTH-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // The pointer's own index is visited last, so the owner only keeps
    // the bus when nobody else is asking.
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      cand_idx = MID_WIDTH'(cand);
      if (!any_o && req_i[cand_idx]) begin
        grant_o           = '0;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
        any_o             = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: grants one master at legal arbitration points, never splits
// locked sequences or fixed bursts. ARB_FIXED_PRIO_EN selects fixed priority.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int MID_WIDTH   = 2,
  parameter int DEFAULT_MST = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic                   HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MID_WIDTH-1:0]   HMASTER,
  output logic                   HMASTLOCK
);

  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MST;
  localparam logic [MID_WIDTH-1:0]   DEF_IDX   = MID_WIDTH'(DEFAULT_MST);

  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MID_WIDTH-1:0]   owner_q, owner_d;
  logic [MID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [MID_WIDTH-1:0]   master_q, master_d;
  logic                   mastlock_q, mastlock_d;
  logic                   lock_hold_q, lock_hold_d;
  logic                   err_q, err_d;
  logic [BEAT_CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [NUM_MASTERS-1:0] win_oh, new_grant;
  logic [MID_WIDTH-1:0]   win_idx, new_idx;
  logic                   win_any;
  logic                   arb_point, owner_locked, rearb, err_start;
  htrans_e                trans;
  hburst_e                burst;

  ahb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .MID_WIDTH  (MID_WIDTH)
  ) u_picker (
    .req_i  (HBUSREQ),
    .ptr_i  (rr_ptr_q),
    .grant_o(win_oh),
    .idx_o  (win_idx),
    .any_o  (win_any)
  );

  always_comb begin
    trans     = htrans_e'(HTRANS);
    burst     = hburst_e'(HBURST);
    new_grant = win_any ? win_oh  : DEF_GRANT;
    new_idx   = win_any ? win_idx : DEF_IDX;
    err_start = HRESP && !HREADY;
    // err_q makes the HREADY edge that ends an ERROR response an arb point.
    arb_point = (trans == HTRANS_IDLE)
             || (trans == HTRANS_NONSEQ && (burst == HBURST_SINGLE || burst == HBURST_INCR))
             || (trans == HTRANS_SEQ && beat_cnt_q == 4'd1)
             || (trans == HTRANS_SEQ && burst == HBURST_INCR)
             || err_q;
    owner_locked = HLOCK[owner_q] && HBUSREQ[owner_q];
    rearb        = HREADY && arb_point && !(lock_hold_q && owner_locked);
  end

  always_comb begin
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    master_d    = master_q;
    mastlock_d  = mastlock_q;
    lock_hold_d = lock_hold_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;

    if (err_start) begin
      err_d       = 1'b1;
      lock_hold_d = 1'b0;
      beat_cnt_d  = '0;
    end else if (HREADY) begin
      err_d      = 1'b0;
      master_d   = owner_q;
      mastlock_d = lock_hold_q;
      if (trans == HTRANS_NONSEQ) begin
        beat_cnt_d = burst_beats_left(burst);
      end else if (trans == HTRANS_SEQ && beat_cnt_q != '0) begin
        beat_cnt_d = beat_cnt_q - 4'd1;
      end
      if (rearb) begin
        grant_d     = new_grant;
        owner_d     = new_idx;
        lock_hold_d = HLOCK[new_idx] && HBUSREQ[new_idx];
`ifdef ARB_FIXED_PRIO_EN
        rr_ptr_d    = DEF_IDX;
`else
        if (new_idx != owner_q) rr_ptr_d = new_idx;
`endif
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q     <= DEF_GRANT;
      owner_q     <= DEF_IDX;
      rr_ptr_q    <= DEF_IDX;
      master_q    <= DEF_IDX;
      mastlock_q  <= 1'b0;
      lock_hold_q <= 1'b0;
      err_q       <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      master_q    <= master_d;
      mastlock_q  <= mastlock_d;
      lock_hold_q <= lock_hold_d;
      err_q       <= err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter; expectations follow ARB_FIXED_PRIO_EN.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_WRAP4  = 3'b010;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] HBUSREQ = '0;
  logic [3:0] HLOCK = '0;
  logic [1:0] HTRANS = T_IDLE;
  logic [2:0] HBURST = B_SINGLE;
  logic       HREADY = 1'b1;
  logic       HRESP = 1'b0;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  ahb_bus_arbiter #(.NUM_MASTERS(4), .MID_WIDTH(2), .DEFAULT_MST(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] ex(input logic [3:0] g, input int m, input logic l);
    return {g, 2'(m), l};
  endfunction

  // One bus cycle: apply inputs, queue the expected outputs, sample after the edge.
  task automatic drive(input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic rsp, input logic [3:0] req, input logic [3:0] lk,
                       input logic [6:0] exp_v);
    HTRANS = tr; HBURST = bu; HREADY = rdy; HRESP = rsp; HBUSREQ = req; HLOCK = lk;
    exp_q.push_back(exp_v);
    @(posedge HCLK);
    #1;
    obs_q.push_back({HGRANT, HMASTER, HMASTLOCK});
  endtask

  task automatic apply_reset();
    HRESETn = 1'b0; HBUSREQ = '0; HLOCK = '0; HTRANS = T_IDLE; HBURST = B_SINGLE;
    HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0000, 4'b0000, ex(4'b0001, 2, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 0, 0));
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HGRANT, HMASTER, HMASTLOCK} !== 7'b0001_00_0) begin
      errors++;
      $display("FAIL reset_async: got g=%b m=%0d l=%b, want g=0001 m=0 l=0", HGRANT, HMASTER, HMASTLOCK);
    end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0000, 4'b0000, ex(4'b0001, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0000, 4'b0000, ex(4'b0001, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_rr_single();
    logic [6:0] e, o; int n = 0;
    apply_reset();
`ifdef ARB_FIXED_PRIO_EN
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
`else
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0100, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0010, 2, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0110, 4'b0000, ex(4'b0100, 1, 0));
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rr_single beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_fixed_burst();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 2, 0));
    drive(T_NSEQ, B_INCR8,  1, 0, 4'b1100, 4'b0000, ex(4'b0100, 2, 0));
    for (int i = 0; i < 3; i++)
      drive(T_SEQ, B_INCR8, 1, 0, 4'b1100, 4'b0000, ex(4'b0100, 2, 0));
    // Owner withdraws its request mid-burst; the burst must still finish.
    for (int i = 0; i < 3; i++)
      drive(T_SEQ, B_INCR8, 1, 0, 4'b1000, 4'b0000, ex(4'b0100, 2, 0));
    drive(T_SEQ,  B_INCR8,  1, 0, 4'b1000, 4'b0000, ex(4'b1000, 2, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b1000, 4'b0000, ex(4'b1000, 3, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL incr8_burst beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_lock();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0011, 4'b0010, ex(4'b0010, 0, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0011, 4'b0010, ex(4'b0010, 1, 1));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b0011, 4'b0010, ex(4'b0010, 1, 1));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0011, 4'b0000, ex(4'b0001, 1, 1));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0001, 4'b0000, ex(4'b0001, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL lock beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_hready_stall();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0010, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0010, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_INCR4,  1, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    for (int i = 0; i < 3; i++)
      drive(T_SEQ, B_INCR4, 0, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_SEQ,  B_INCR4,  1, 0, 4'b0100, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_SEQ,  B_INCR4,  1, 0, 4'b0100, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_SEQ,  B_INCR4,  1, 0, 4'b0100, 4'b0000, ex(4'b0100, 1, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 2, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hready_stall beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_error();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0010, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0010, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_WRAP4,  1, 0, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_SEQ,  B_WRAP4,  0, 1, 4'b0110, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_SEQ,  B_WRAP4,  1, 1, 4'b0100, 4'b0000, ex(4'b0100, 1, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 2, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL error_resp beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_priority();
    logic [6:0] e, o; int n = 0;
    apply_reset();
`ifdef ARB_FIXED_PRIO_EN
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 1, 0));
`else
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 0, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b1000, 1, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 3, 0));
    drive(T_NSEQ, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b1000, 1, 0));
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL priority beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e, o; int n = 0;
    int gi = 0, mi = 0;
    logic rdy;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      rdy = 1'($urandom_range(0, 1));
      if (rdy) begin
        mi = gi;
`ifdef ARB_FIXED_PRIO_EN
        gi = 1;
`else
        gi = (gi == 1) ? 2 : 1;
`endif
      end
      drive(T_NSEQ, B_SINGLE, rdy, 0, 4'b0110, 4'b0000, ex(4'b0001 << gi, mi, 0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] e, o; int n = 0;
    apply_reset();
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 0, 0));
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b0100, 4'b0000, ex(4'b0100, 2, 0));
    drive(T_NSEQ, B_INCR8,  1, 0, 4'b1100, 4'b0000, ex(4'b0100, 2, 0));
    drive(T_SEQ,  B_INCR8,  1, 0, 4'b1100, 4'b0000, ex(4'b0100, 2, 0));
    #2 HRESETn = 1'b0;
    #1;
    checks++;
    if ({HGRANT, HMASTER, HMASTLOCK} !== 7'b0001_00_0) begin
      errors++;
      $display("FAIL reset_mid_burst: got g=%b m=%0d l=%b, want g=0001 m=0 l=0", HGRANT, HMASTER, HMASTLOCK);
    end
    @(posedge HCLK); #1 HRESETn = 1'b1;
    // Round-robin pointer must restart from DEFAULT_MST, so M1 precedes M3.
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 0, 0));
`ifdef ARB_FIXED_PRIO_EN
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b0010, 1, 0));
`else
    drive(T_IDLE, B_SINGLE, 1, 0, 4'b1010, 4'b0000, ex(4'b1000, 1, 0));
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid_burst beat %0d: got g=%b m=%0d l=%b, want g=%b m=%0d l=%b", n, o[6:3], o[2:1], o[0], e[6:3], e[2:1], e[0]);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_fixed_burst();
    test_lock();
    test_hready_stall();
    test_error();
    test_priority();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
